// File: rtl/matrix_rx_parser_if.sv
`default_nettype none
// ============================================================================
// matrix_rx_parser_if : byte-stream request side and parsed-matrix result side
// Rev 1.0
// ============================================================================
interface matrix_rx_parser_if #(
  parameter int ELEM_WIDTH = 8,
  parameter int MAX_DIM    = 5
);
  localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_WIDTH;

  logic             start;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic [3:0]       m_out;
  logic [3:0]       n_out;
  logic [MAT_W-1:0] mat_out;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, rx_valid, rx_data,
    input  m_out, n_out, mat_out, busy, done, error
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output m_out, n_out, mat_out, busy, done, error
  );
endinterface
`default_nettype wire

// File: rtl/matrix_rx_parser.sv
`default_nettype none
// ============================================================================
// matrix_rx_parser : parses ASCII "m n e0 e1 ..." into a packed row-major matrix
// Rev 1.0
// ============================================================================
module matrix_rx_parser #(
  parameter int ELEM_WIDTH = 8,
  parameter int MAX_DIM    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  matrix_rx_parser_if.slave bus
);
  localparam int NELEM    = MAX_DIM * MAX_DIM;
  localparam int MAT_W    = NELEM * ELEM_WIDTH;
  localparam int IDX_W    = 5;
  localparam int ELEM_MAX = (1 << ELEM_WIDTH) - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DIM_M = 3'd1;
  localparam logic [2:0] S_DIM_N = 3'd2;
  localparam logic [2:0] S_ELEM  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [9:0]       acc_q, acc_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic             have_q, have_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       m_q, m_d, n_q, n_d;
  logic [MAT_W-1:0] mat_q, mat_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic             w_is_digit, w_is_sep, w_wr, w_fail;
  logic [9:0]       w_digit, w_acc_next;
  logic [IDX_W-1:0] w_mn;

  assign w_is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign w_is_sep   = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) ||
                      (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h09);
  assign w_digit    = {2'b00, bus.rx_data - 8'h30};
  // At most three digits reach here, so acc never exceeds 999 and 10 bits suffice.
  assign w_acc_next = acc_q * 10'd10 + w_digit;
  assign w_mn       = {1'b0, m_q} * {1'b0, n_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dcnt_d  = dcnt_q;
    have_d  = have_q;
    idx_d   = idx_q;
    m_d     = m_q;
    n_d     = n_q;
    mat_d   = mat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    w_wr    = 1'b0;
    w_fail  = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.start) begin
        mat_d   = '0;
        m_d     = 4'd0;
        n_d     = 4'd0;
        acc_d   = 10'd0;
        dcnt_d  = 2'd0;
        have_d  = 1'b0;
        idx_d   = '0;
        busy_d  = 1'b1;
        state_d = S_DIM_M;
      end
    end else if (state_q >= S_ERR) begin
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end else if (bus.rx_valid) begin
      if (w_is_digit) begin
        if (dcnt_q == 2'd3) begin
          w_fail = 1'b1;
        end else begin
          acc_d  = w_acc_next;
          dcnt_d = dcnt_q + 2'd1;
          have_d = 1'b1;
        end
      end else if (w_is_sep) begin
        if (have_q) begin
          acc_d  = 10'd0;
          dcnt_d = 2'd0;
          have_d = 1'b0;
          if (state_q == S_DIM_M || state_q == S_DIM_N) begin
            if (acc_q == 10'd0 || 32'(acc_q) > MAX_DIM) begin
              w_fail = 1'b1;
            end else if (state_q == S_DIM_M) begin
              m_d     = acc_q[3:0];
              state_d = S_DIM_N;
            end else begin
              n_d     = acc_q[3:0];
              idx_d   = '0;
              state_d = S_ELEM;
            end
          end else if (32'(acc_q) > ELEM_MAX) begin
            w_fail = 1'b1;
          end else begin
            w_wr = 1'b1;
            if (idx_q == w_mn - 5'd1) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
      end else begin
        w_fail = 1'b1;
      end
    end

    for (int k = 0; k < NELEM; k++) begin
      if (w_wr && idx_q == IDX_W'(k)) begin
        mat_d[k*ELEM_WIDTH +: ELEM_WIDTH] = acc_q[ELEM_WIDTH-1:0];
      end
    end

    // Abort keeps m/n/matrix contents; only the token state is dropped.
    if (w_fail) begin
      acc_d   = 10'd0;
      dcnt_d  = 2'd0;
      have_d  = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b1;
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 10'd0;
      dcnt_q  <= 2'd0;
      have_q  <= 1'b0;
      idx_q   <= '0;
      m_q     <= 4'd0;
      n_q     <= 4'd0;
      mat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dcnt_q  <= dcnt_d;
      have_q  <= have_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      n_q     <= n_d;
      mat_q   <= mat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_out   = m_q;
  assign bus.n_out   = n_q;
  assign bus.mat_out = mat_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.error   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_matrix_rx_parser.sv
`default_nettype none
// ============================================================================
// tb_matrix_rx_parser : directed vector table, reset/idle sequences, random streams
// Rev 1.0
// ============================================================================
module tb_matrix_rx_parser;
  localparam int EW = 8;
  localparam int MD = 5;
  localparam int MW = MD * MD * EW;

  typedef struct {
    string          s;
    int             oc;   // 0 none, 1 done, 2 error
    int             pos;  // byte index where the outcome appears, -1 = last byte
    logic [3:0]     m;
    logic [3:0]     n;
    logic [MW-1:0]  mat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matrix_rx_parser_if #(.ELEM_WIDTH(EW), .MAX_DIM(MD)) bus ();
  matrix_rx_parser #(.ELEM_WIDTH(EW), .MAX_DIM(MD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (bus.done)              done_cnt++;
    if (bus.error)             err_cnt++;
    if (bus.done && bus.error) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  function automatic vec_t mk(string s, int oc, int pos, logic [3:0] m, logic [3:0] n,
                              logic [MW-1:0] mat);
    vec_t v;
    v.s = s; v.oc = oc; v.pos = pos; v.m = m; v.n = n; v.mat = mat;
    return v;
  endfunction

  // Token-level reference: split into tokens, read m, n, then the element list.
  function automatic void model(input string s, output int oc, output int pos,
                                output logic [3:0] m, output logic [3:0] n,
                                output logic [MW-1:0] mat);
    int tok[$];
    int val = 0, nd = 0, k, v;
    logic [7:0] c;
    oc = 0; pos = -1; m = 0; n = 0; mat = '0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= "0" && c <= "9") begin
        if (nd == 3) begin oc = 2; pos = i; return; end
        val = val * 10 + int'(c - "0");
        nd++;
      end else if (c == " " || c == 8'h0D || c == 8'h0A || c == 8'h09) begin
        if (nd > 0) begin
          v = val; val = 0; nd = 0;
          tok.push_back(v);
          k = tok.size() - 1;
          if (k < 2) begin
            if (v < 1 || v > MD) begin oc = 2; pos = i; return; end
            if (k == 0) m = 4'(v); else n = 4'(v);
          end else begin
            if (v > 255) begin oc = 2; pos = i; return; end
            mat[(k-2)*EW +: EW] = 8'(v);
            if (k - 2 == int'(m) * int'(n) - 1) begin oc = 1; pos = i; return; end
          end
        end
      end else begin
        oc = 2; pos = i; return;
      end
    end
  endfunction

  task automatic run_stream(input string s, input bit noise, output int oc, output int pos);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_m_clear", bus.m_out, 0);
    chk("start_n_clear", bus.n_out, 0);
    chk("start_mat_clear", bus.mat_out, 0);
    chk("start_busy", bus.busy, 1);
    oc = 0; pos = -1;
    for (int i = 0; i < s.len(); i++) begin
      if (noise) begin
        repeat ($urandom_range(0, 2)) begin
          bus.start = 1'($urandom_range(0, 1));
          tick();
          bus.start = 1'b0;
        end
      end
      send_byte(s[i]);
      if (bus.done || bus.error) begin
        oc  = bus.done ? 1 : 2;
        pos = i;
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic run_and_check(input string tag, input string s, input bit noise,
                               input int eoc, input int epos, input logic [3:0] em,
                               input logic [3:0] en, input logic [MW-1:0] emat);
    int d0, e0, oc, pos;
    d0 = done_cnt; e0 = err_cnt;
    run_stream(s, noise, oc, pos);
    chk({tag, "_outcome"}, oc, eoc);
    chk({tag, "_pos"}, pos, epos);
    chk({tag, "_m"}, bus.m_out, em);
    chk({tag, "_n"}, bus.n_out, en);
    chk({tag, "_mat"}, bus.mat_out, emat);
    chk({tag, "_busy_after"}, bus.busy, 0);
    chk({tag, "_done_pulses"}, done_cnt - d0, (eoc == 1) ? 1 : 0);
    chk({tag, "_err_pulses"}, err_cnt - e0, (eoc == 2) ? 1 : 0);
  endtask

  function automatic string sep_run(int lo);
    string r = "";
    int k = $urandom_range(lo, 3);
    for (int i = 0; i < k; i++) begin
      case ($urandom_range(0, 3))
        0:       r = {r, " "};
        1:       r = {r, "\r"};
        2:       r = {r, "\n"};
        default: r = {r, "\t"};
      endcase
    end
    return r;
  endfunction

  function automatic string tok_str(int v);
    int p = $urandom_range(0, 29);
    if (p == 0) return $sformatf("%04d", v);
    if (p == 1 && v < 100) return $sformatf("%03d", v);
    if (p == 2) return $sformatf("%0dq", v);
    return $sformatf("%0d", v);
  endfunction

  function automatic string gen();
    int m = ($urandom_range(0, 11) == 0) ? 6 * $urandom_range(0, 1) : $urandom_range(1, 5);
    int n = ($urandom_range(0, 11) == 0) ? 6 * $urandom_range(0, 1) : $urandom_range(1, 5);
    int cnt = (m < 1 || m > MD || n < 1 || n > MD) ? 1 : m * n;
    int e;
    string s = sep_run(0);
    s = {s, tok_str(m), sep_run(1), tok_str(n), sep_run(1)};
    for (int k = 0; k < cnt; k++) begin
      e = ($urandom_range(0, 39) == 0) ? $urandom_range(256, 999) : $urandom_range(0, 255);
      s = {s, tok_str(e), sep_run(1)};
    end
    return s;
  endfunction

  initial begin
    vec_t          tbl[$];
    string         s2;
    int            epos, moc, mpos, d0, e0;
    logic [3:0]    mm, mn;
    logic [MW-1:0] mmat;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    #1;
    chk("rst_m", bus.m_out, 0);
    chk("rst_n", bus.n_out, 0);
    chk("rst_mat", bus.mat_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    s2 = "5\r\n5\r\n";
    for (int i = 0; i < 25; i++) s2 = {s2, "255 "};
    tbl.push_back(mk("2 3 1 2 3 4 5 6\n", 1, 15, 4'd2, 4'd3, MW'(48'h060504030201)));
    tbl.push_back(mk(s2, 1, -1, 4'd5, 4'd5, {25{8'hFF}}));
    tbl.push_back(mk("6 2 ", 2, 1, 4'd0, 4'd0, '0));
    tbl.push_back(mk("1 1 256 ", 2, 7, 4'd1, 4'd1, '0));
    tbl.push_back(mk("1 1 12a", 2, 6, 4'd1, 4'd1, '0));
    tbl.push_back(mk("\t2  3\r\n\r\n1 2\t3  4 5\t\t6\r", 1, -1, 4'd2, 4'd3,
                     MW'(48'h060504030201)));
    tbl.push_back(mk("1 1 1234 ", 2, 7, 4'd1, 4'd1, '0));
    tbl.push_back(mk("3 0 ", 2, 3, 4'd3, 4'd0, '0));
    tbl.push_back(mk("1 1 0\n", 1, -1, 4'd1, 4'd1, '0));
    tbl.push_back(mk("5 1 999 ", 2, 7, 4'd5, 4'd1, '0));
    tbl.push_back(mk("2 1 17 200 ", 1, -1, 4'd2, 4'd1, MW'(16'hC811)));

    foreach (tbl[t]) begin
      epos = (tbl[t].pos < 0) ? tbl[t].s.len() - 1 : tbl[t].pos;
      run_and_check($sformatf("vec%0d", t), tbl[t].s, (t % 2) == 1,
                    tbl[t].oc, epos, tbl[t].m, tbl[t].n, tbl[t].mat);
    end

    // Idle strobes after a completed parse must not disturb the result.
    run_and_check("idle_pre", "2 3 1 2 3 4 5 6\n", 1'b0, 1, 15, 4'd2, 4'd3,
                  MW'(48'h060504030201));
    d0 = done_cnt; e0 = err_cnt;
    foreach (s2[i]) begin
      if (i >= 8) break;
      send_byte(s2[i]);
    end
    send_byte("x");
    tick();
    chk("idle_m", bus.m_out, 2);
    chk("idle_n", bus.n_out, 3);
    chk("idle_mat", bus.mat_out, MW'(48'h060504030201));
    chk("idle_busy", bus.busy, 0);
    chk("idle_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    // Reset in the middle of a parse.
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    foreach (s2[i]) if (i < 0) send_byte(8'h00);
    send_byte("2"); send_byte(" "); send_byte("2"); send_byte(" ");
    send_byte("7"); send_byte(" ");
    chk("mid_m", bus.m_out, 2);
    chk("mid_mat", bus.mat_out, MW'(8'h07));
    d0 = done_cnt; e0 = err_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_m", bus.m_out, 0);
    chk("arst_n", bus.n_out, 0);
    chk("arst_mat", bus.mat_out, 0);
    chk("arst_busy", bus.busy, 0);
    tick(); tick();
    chk("arst_hold_busy", bus.busy, 0);
    chk("arst_hold_mat", bus.mat_out, 0);
    chk("arst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    rst_n = 1'b1;
    tick();
    run_and_check("post_rst", "1 1 9\n", 1'b0, 1, 5, 4'd1, 4'd1, MW'(8'h09));

    for (int r = 0; r < 40; r++) begin
      s2 = gen();
      model(s2, moc, mpos, mm, mn, mmat);
      run_and_check($sformatf("rnd%0d", r), s2, 1'b1, moc, mpos, mm, mn, mmat);
    end

    chk("done_error_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/matrix_rx_parser.md
MATRIX_RX_PARSER -- requirements
Module: matrix_rx_parser

Interface
REQ-001 The block SHALL take parameter ELEM_WIDTH, default 8, as the element width in bits.
REQ-002 The block SHALL take parameter MAX_DIM, default 5, as the maximum row count and maximum column count.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin parsing a new matrix.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid for that cycle.
REQ-007 rx_data  input  8  received ASCII byte.
REQ-008 m_out  output  4  parsed row count.
REQ-009 n_out  output  4  parsed column count.
REQ-010 mat_out  output  200  packed matrix; element k SHALL be at bits [k*8 +: 8], in row-major order, k = i*n + j.
REQ-011 busy  output  1  high while a parse is in progress.
REQ-012 done  output  1  one-cycle pulse when a matrix has been parsed successfully.
REQ-013 error  output  1  one-cycle pulse when a parse is aborted.

Function
REQ-014 The FSM SHALL have the states S_IDLE, S_DIM_M, S_DIM_N, S_ELEM and S_ERR.
REQ-015 In S_IDLE, a start pulse SHALL clear mat_out, m_out and n_out to 0, set busy, and move the FSM to S_DIM_M.
REQ-016 A start pulse while busy is high SHALL be ignored.
REQ-017 An rx_valid strobe in S_IDLE SHALL be ignored.
REQ-018 Only bytes sampled with rx_valid=1 SHALL be processed, one byte per strobe.
REQ-019 A digit byte (0x30-0x39) SHALL update acc <= acc*10 + digit, set have_digit, and increment dcnt.
- acc is 10 bits wide.
- dcnt is a digit counter.
REQ-020 A separator byte (0x20, 0x0D, 0x0A or 0x09) with have_digit=1 SHALL commit the token and then clear acc, have_digit and dcnt.
REQ-021 A separator byte with have_digit=0 SHALL be ignored, so that runs of separators collapse.
REQ-022 A token commit in S_DIM_M SHALL latch m_out and move the FSM to S_DIM_N.
REQ-023 A token commit in S_DIM_N SHALL latch n_out, clear the element index idx, and move the FSM to S_ELEM.
REQ-024 A token commit in S_ELEM SHALL write acc[7:0] to element idx and then increment idx.
REQ-025 The commit of element idx = m*n-1 SHALL, on the same edge, clear busy, pulse done high for the following cycle, and return the FSM to S_IDLE.
REQ-026 The last element SHALL require a terminating separator before it commits; no timeout applies.
REQ-027 The FSM SHALL enter S_ERR on any of these conditions:
- a byte that is neither a digit nor a separator;
- a 4th digit in one token;
- a committed element greater than 255;
- a committed m or n equal to 0 or greater than MAX_DIM.
REQ-028 S_ERR SHALL pulse error for exactly one cycle, clear busy, and return the FSM to S_IDLE on the next edge.
REQ-029 On error, mat_out, m_out and n_out SHALL keep their partial contents until the next start.
REQ-030 Matrix slots at or above index m*n SHALL remain 0.
REQ-031 m*n SHALL be computed at 5-bit width, and idx SHALL be 5 bits wide.
REQ-032 done and error SHALL never be high in the same cycle.

Reset
REQ-033 While rst_n=0, all outputs SHALL be 0: mat_out, m_out, n_out, busy, done and error.
REQ-034 While rst_n=0, the FSM SHALL be in S_IDLE with acc, dcnt, have_digit and idx cleared.
REQ-035 Reset asserted mid-parse SHALL abandon the parse immediately, with no done or error pulse.
REQ-036 After reset is released, the block SHALL accept a new start pulse.

Verification
REQ-037 Scenario 1: start, then the bytes "2 3 1 2 3 4 5 6\n".
- m_out=2 and n_out=3.
- mat_out bytes 0..5 = 1..6; bytes 6..24 = 0.
- done pulses exactly once, in the cycle after the 0x0A byte is sampled.
- busy then reads 0.
REQ-038 Scenario 2: start, then "5\r\n5\r\n" followed by 25 copies of "255 ".
- All 25 bytes of mat_out = 0xFF.
- done pulses once.
REQ-039 Scenario 3: start, then "6 2 ".
- error pulses once, in the cycle after the space following "6" is sampled.
- done never asserts, and m_out stays 0.
REQ-040 Scenario 4: start, then "1 1 256 ".
- error pulses once.
- Second variant: start, then "1 1 12a". error pulses on 'a'.
REQ-041 Scenario 5: start, send "2 2 7 ", then pull rst_n low.
- All outputs read 0 while reset is held.
- A fresh start followed by "1 1 9\n" gives mat_out[7:0]=9 and a done pulse.
REQ-042 Scenario 6: start pulses while busy, and rx_valid strobes while idle.
- Neither changes any output.
- Any number of extra separators between tokens leaves the result unchanged.
